// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, exponent limits, state encoding and float packing for the FP normalizer
package fp_pkg;

    localparam int SUM_W  = 24;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFE;
    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [EXP_W+FRAC_W:0] pack_float(
        input logic              sign,
        input logic [EXP_W-1:0]  exp,
        input logic [FRAC_W-1:0] frac
    );
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/man_normalizer_lzc25.sv
// rtl/man_normalizer_lzc25.sv - 25-bit leading-zero counter (module lzc25), used only when NORM_LZC_EN is defined
module lzc25 (
    input  logic [24:0] din,
    output logic [4:0]  count
);

    // The highest set bit wins because later loop iterations overwrite earlier ones
    always_comb begin
        count = 5'd25;
        for (int i = 0; i < 25; i++) begin
            if (din[i]) begin
                count = 5'(24 - i);
            end
        end
    end

endmodule

// File: rtl/man_normalizer.sv
// rtl/man_normalizer.sv - renormalizes the mantissa-adder result and packs an IEEE-754 single; NORM_LZC_EN selects single-cycle normalization
module man_normalizer
    import fp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SUM_W+1:0]        in_result,
    input  logic [EXP_W-1:0]        in_exp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_float,
    output logic                    overflow,
    output logic                    underflow
);

    state_t state, state_nxt;

    // Working mantissa: bit 24 is the carry, bit 23 the hidden one
    logic [SUM_W:0]          w_q;
    logic [EXP_W-1:0]        e_q;
    logic                    s_q;
    logic                    z_q;

    logic [EXP_W:0]          e_inc;
    logic [EXP_W+FRAC_W:0]   res;
    logic                    ovf;
    logic                    unf;
    logic                    norm_done;

`ifdef NORM_LZC_EN
    logic [4:0]              lzc;
    logic [FRAC_W-1:0]       w_shl;

    // Sentinel in the LSB keeps the count bounded; it equals the left-shift distance
    lzc25 u_lzc (
        .din   ({w_q[SUM_W-1:0], 1'b1}),
        .count (lzc)
    );
`else
    logic [SUM_W:0]          w_nxt;
    logic [EXP_W-1:0]        e_nxt;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, leave NORM once resolved, release DONE on the output handshake
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = NORM;
            NORM:    if (norm_done) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One NORM step: zero, carry (right shift), normalized, or left shift with underflow flush
    always_comb begin
        res       = '0;
        ovf       = 1'b0;
        unf       = 1'b0;
        norm_done = 1'b0;
        e_inc     = {1'b0, e_q} + 9'd1;
`ifdef NORM_LZC_EN
        w_shl     = FRAC_W'(w_q << lzc);
`else
        w_nxt     = w_q;
        e_nxt     = e_q;
`endif
        if (z_q || (w_q == '0)) begin
            res       = pack_float(s_q, '0, '0);
            norm_done = 1'b1;
        end else if (w_q[SUM_W]) begin
            if (e_inc > {1'b0, EXP_MAX}) begin
                res       = pack_float(s_q, EXP_INF, '0);
                ovf       = 1'b1;
                norm_done = 1'b1;
            end else begin
`ifdef NORM_LZC_EN
                res       = pack_float(s_q, e_inc[EXP_W-1:0], w_q[SUM_W-1:1]);
                norm_done = 1'b1;
`else
                w_nxt     = w_q >> 1;
                e_nxt     = e_inc[EXP_W-1:0];
`endif
            end
        end else if (w_q[SUM_W-1]) begin
            res       = pack_float(s_q, e_q, w_q[FRAC_W-1:0]);
            norm_done = 1'b1;
        end else begin
`ifdef NORM_LZC_EN
            if ({3'b000, lzc} >= e_q) begin
                res = pack_float(s_q, '0, '0);
                unf = 1'b1;
            end else begin
                res = pack_float(s_q, e_q - {3'b000, lzc}, w_shl);
            end
            norm_done = 1'b1;
`else
            w_nxt = w_q << 1;
            e_nxt = e_q - 8'd1;
            // This shift drives the exponent to zero, so the result cannot be normal
            if (e_q <= 8'd1) begin
                res       = pack_float(s_q, '0, '0);
                unf       = 1'b1;
                norm_done = 1'b1;
            end
`endif
        end
    end

    // Datapath: capture on accept, iterate in NORM, latch the packed result when NORM resolves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q       <= '0;
            e_q       <= '0;
            s_q       <= 1'b0;
            z_q       <= 1'b0;
            out_float <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (in_valid && in_ready) begin
            w_q       <= {in_result[SUM_W-1:0], 1'b0};
            e_q       <= in_exp;
            s_q       <= in_result[SUM_W];
            z_q       <= in_result[SUM_W+1];
            out_float <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (state == NORM) begin
`ifndef NORM_LZC_EN
            w_q <= w_nxt;
            e_q <= e_nxt;
`endif
            if (norm_done) begin
                out_float <= res;
                overflow  <= ovf;
                underflow <= unf;
            end
        end
    end

endmodule
